// File: rtl/dcache_responder.sv
// Direct-mapped, write-through/no-allocate data cache between a core and backing memory.
// Load hit responds 2 cycles after acceptance; misses and stores hold mem_req until mem_ack.
module dcache_responder #(
  parameter int LINES = 16,
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        data_ready,
  output logic [63:0] data_response,
  output logic        busy,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 64 - IDX_W - 3;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_READ,
    MEM_WRITE,
    RESPOND
  } state_t;

  state_t state, state_nxt;

  logic              lat_write;
  logic [63:3]       lat_addr;
  logic [63:0]       lat_wdata;

  logic [LINES-1:0]  line_valid;
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [63:0]       line_data [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              accept;
  logic              unused_addr_bits;

  // Byte offset within the word never affects lookup or memory traffic.
  assign unused_addr_bits = ^req_addr[2:0];

  assign idx    = lat_addr[IDX_W+2:3];
  assign tag    = lat_addr[63:IDX_W+3];
  assign hit    = line_valid[idx] && (line_tag[idx] == tag);
  assign accept = (state == IDLE) && req_valid && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 64'd0;
    mem_wdata  = 64'd0;
    data_ready = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (lat_write)  state_nxt = MEM_WRITE;
        else if (hit)   state_nxt = RESPOND;
        else            state_nxt = MEM_READ;
      end
      MEM_READ: begin
        mem_req  = 1'b1;
        mem_addr = {lat_addr, 3'b000};
        if (mem_ack) state_nxt = RESPOND;
      end
      MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {lat_addr, 3'b000};
        mem_wdata = lat_wdata;
        if (mem_ack) state_nxt = RESPOND;
      end
      RESPOND: begin
        data_ready = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_write     <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= 64'd0;
      line_valid    <= '0;
      data_response <= 64'd0;
      hit_count     <= 32'd0;
      miss_count    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            line_valid <= '0;
          end else if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr[63:3];
            lat_wdata <= req_wdata;
          end
        end
        LOOKUP: begin
          if (!lat_write) begin
            if (hit) begin
              data_response <= line_data[idx];
              hit_count     <= hit_count + 32'd1;
            end else begin
              miss_count <= miss_count + 32'd1;
            end
          end
        end
        MEM_READ: begin
          if (mem_ack) begin
            line_valid[idx] <= 1'b1;
            data_response   <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && lat_write && hit) begin
      line_data[idx] <= lat_wdata;
    end else if (state == MEM_READ && mem_ack) begin
      line_tag[idx]  <= tag;
      line_data[idx] <= mem_rdata;
    end
  end

endmodule
